clb_cfg_loader: RTL and testbench
=================================

Name: clb_cfg_loader

Overview:
- Serial configuration loader sitting directly upstream of the CLB.
- Deserialises a framed configuration bitstream into the CLB's 37-bit parallel configuration word: LUT memory, combinational option, mux selects, DQ muxes and flop/latch select.
- Verifies parity and updates the CLB-facing configuration atomically; a corrupt frame never reaches the CLB.

Parameters:
- CFG_W, 37, configuration word width.
- CFG_INIT, 37'h0_380A_80116, power-on/reset configuration word (CLB default personality).
- PREAMBLE, 4'b0010, frame start pattern.

Ports:
- K  input  1  clock, rising edge.
- RSTN  input  1  reset: synchronous, active-low.
- DIN  input  1  serial configuration data, MSB of the word first.
- DVALID  input  1  DIN qualifier; low stalls the loader (no state, count or shift change).
- CFG  output  CFG_W  configuration word to the CLB.
- CFG_DONE  output  1  one-cycle pulse on a successful load.
- CFG_ERR  output  1  sticky parity-error flag.
- BUSY  output  1  high while a frame body is being received.

Behaviour:
- CFG bit map:
  - [15:0] mem
  - [17:16] comboption
  - [19:18] mux2select, [21:20] mux3select, [23:22] mux4select, [25:24] mux5select, [27:26] mux6select
  - [28] o2m1_0, [29] o2m2_0, [30] o2m3_0, [31] o2m1_1, [32] o2m2_1, [33] o2m3_1
  - [34] DQmux1, [35] DQmux2, [36] floporlatch
- Reset (RSTN low at a K edge, overrides everything, including mid-frame):
  - CFG=CFG_INIT, CFG_DONE=0, CFG_ERR=0, BUSY=0.
  - Shift register=0, bit counter=0, preamble window=0, state=IDLE.
- All outputs are registered. Only edges with DVALID=1 advance the machine.
- IDLE:
  - Window <= {win[2:0],DIN}.
  - If {win[2:0],DIN}==PREAMBLE, go to DATA with counter=0 and window=0.
  - BUSY=0.
- DATA:
  - Shift <= {shift[CFG_W-2:0],DIN}; counter increments.
  - After CFG_W accepted bits (counter reaches CFG_W-1 on the accepting edge), go to PARITY.
  - BUSY=1.
- PARITY:
  - Sample DIN as the parity bit. Required: XOR of the 37 data bits XOR parity bit == 0 (even parity).
  - Pass:
    - CFG <= shift at this edge.
    - CFG_DONE=1 for exactly the following cycle.
    - CFG_ERR cleared.
  - Fail:
    - CFG unchanged.
    - CFG_ERR <= 1, held until a later successful load or reset.
  - Both cases return to IDLE with window=0. BUSY=1 in PARITY.
- CFG changes only on a successful parity edge or on reset; it never shows a partial word.
- Back-to-back frames:
  - Each frame needs a full new 4-bit preamble, because the window is cleared on entry to DATA and on exit from PARITY.
  - Earliest new DONE is 42 valid bits after the previous one.
- Preamble bits inside a frame body are data, not resync.
- The counter is 6 bits and never wraps past CFG_W-1.
- DVALID low during DATA/PARITY: hold indefinitely, BUSY stays 1, no timeout.
- CFG_DONE is never asserted in the same cycle as a CFG_ERR rising edge.

Test Plan:
- Reset:
  - Stimulus: RSTN low 2 cycles, then high, DVALID=0.
  - Required: CFG==37'h0_380A_80116, CFG_DONE=0, CFG_ERR=0, BUSY=0.
- Good frame:
  - Stimulus: send 0010, then 37'h1_0000_FFFF MSB first, then parity 1, DVALID=1 continuously.
  - Required: BUSY high 38 cycles; CFG==37'h1_0000_FFFF and CFG_DONE=1 for exactly one cycle after the parity edge.
- Bad parity:
  - Stimulus: after the good frame, send 0010, 37'h0_0000_0001, parity 0.
  - Required: CFG stays 37'h1_0000_FFFF, CFG_ERR=1, no CFG_DONE. A following good frame clears CFG_ERR.
- Stall:
  - Stimulus: good frame with DVALID dropped for 5 cycles at bit 10 and again in PARITY.
  - Required: same final CFG as the unstalled frame; DONE delayed by exactly the stall cycles.
- Reset mid-frame:
  - Stimulus: RSTN low for 1 cycle after 20 data bits.
  - Required: CFG back to CFG_INIT, BUSY=0. Trailing bits with no fresh 0010 leave CFG unchanged.
- Preamble embedded in noise / in body:
  - Stimulus: 1110010 followed by a frame whose body contains 0010.
  - Required: the frame locks on the first 0010 only; the body is loaded intact with DONE=1.

Source files
------------

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for the CLB: finds the frame preamble, shifts in a parity-protected
// configuration word and commits it to CFG only when the parity bit checks.
module clb_cfg_loader #(
   parameter int unsigned      CFG_W    = 37,
   parameter logic [CFG_W-1:0] CFG_INIT = 37'h0_380A_80116,
   parameter logic [3:0]       PREAMBLE = 4'b0010
) (
   input  logic             K,
   input  logic             RSTN,
   input  logic             DIN,
   input  logic             DVALID,
   output logic [CFG_W-1:0] CFG,
   output logic             CFG_DONE,
   output logic             CFG_ERR,
   output logic             BUSY
);

   localparam logic [5:0] LastBit = 6'(CFG_W - 1);

   typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

   state_e             state_q, state_d;
   logic [2:0]         win_q, win_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [CFG_W-1:0]   shift_q, shift_d;
   logic [CFG_W-1:0]   cfg_q, cfg_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               pre_hit;
   logic               par_ok;

   assign pre_hit = ({win_q, DIN} == PREAMBLE);
   // Even parity over the 37 data bits plus the parity bit itself.
   assign par_ok  = ~((^shift_q) ^ DIN);

   always_ff @(posedge K) begin
      if (!RSTN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (DVALID) begin
         unique case (state_q)
            StIdle:   if (pre_hit) state_d = StData;
            StData:   if (cnt_q == LastBit) state_d = StParity;
            StParity: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      win_d   = win_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      cfg_d   = cfg_q;
      done_d  = 1'b0;
      err_d   = err_q;
      busy_d  = (state_d != StIdle);
      if (DVALID) begin
         unique case (state_q)
            StIdle: begin
               win_d = {win_q[1:0], DIN};
               if (pre_hit) begin
                  win_d = '0;
                  cnt_d = '0;
               end
            end
            StData: begin
               shift_d = {shift_q[CFG_W-2:0], DIN};
               if (cnt_q != LastBit) cnt_d = cnt_q + 6'd1;
            end
            StParity: begin
               win_d = '0;
               if (par_ok) begin
                  cfg_d  = shift_q;
                  done_d = 1'b1;
                  err_d  = 1'b0;
               end else begin
                  err_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge K) begin
      if (!RSTN) begin
         win_q   <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         cfg_q   <= CFG_INIT;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         cfg_q   <= cfg_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign CFG      = cfg_q;
   assign CFG_DONE = done_q;
   assign CFG_ERR  = err_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: framed loads, parity errors, stalls, mid-frame reset
// and preamble hunting in noise.
module tb_clb_cfg_loader;

   localparam logic [36:0] Init = 37'h0_380A_80116;

   logic        K = 1'b0;
   logic        RSTN = 1'b0;
   logic        DIN = 1'b0;
   logic        DVALID = 1'b0;
   logic [36:0] CFG;
   logic        CFG_DONE;
   logic        CFG_ERR;
   logic        BUSY;

   int checks = 0;
   int failures = 0;
   int edges = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   clb_cfg_loader dut (
      .K        (K),
      .RSTN     (RSTN),
      .DIN      (DIN),
      .DVALID   (DVALID),
      .CFG      (CFG),
      .CFG_DONE (CFG_DONE),
      .CFG_ERR  (CFG_ERR),
      .BUSY     (BUSY)
   );

   always #5 K = ~K;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given qualifier/data; outputs sampled 1 time unit later.
   task automatic step(input logic v, input logic b);
      DVALID = v;
      DIN    = b;
      @(posedge K);
      #1;
      edges++;
      if (BUSY === 1'b1) busy_cnt++;
      if (CFG_DONE === 1'b1) done_cnt++;
   endtask

   task automatic send_bits(input logic [63:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, w[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   task automatic start_frame();
      edges    = 0;
      busy_cnt = 0;
      done_cnt = 0;
   endtask

   initial begin
      // Reset
      RSTN = 1'b0;
      idle(2);
      RSTN = 1'b1;
      idle(1);
      chk("reset_cfg", 64'(CFG), 64'(Init));
      chk("reset_done", 64'(CFG_DONE), 64'd0);
      chk("reset_err", 64'(CFG_ERR), 64'd0);
      chk("reset_busy", 64'(BUSY), 64'd0);

      // Good frame, continuous DVALID
      start_frame();
      send_bits(64'b0010, 4);
      chk("good_busy_after_pre", 64'(BUSY), 64'd1);
      send_bits(64'h1_0000_FFFF, 37);
      chk("good_cfg_before_par", 64'(CFG), 64'(Init));
      step(1'b1, 1'b1);
      chk("good_cfg", 64'(CFG), 64'h1_0000_FFFF);
      chk("good_done", 64'(CFG_DONE), 64'd1);
      chk("good_busy_cycles", 64'(busy_cnt), 64'd38);
      chk("good_done_edge", 64'(edges), 64'd42);
      chk("good_busy_end", 64'(BUSY), 64'd0);
      idle(1);
      chk("good_done_pulse", 64'(CFG_DONE), 64'd0);
      chk("good_done_count", 64'(done_cnt), 64'd1);

      // Bad parity
      start_frame();
      send_bits(64'b0010, 4);
      send_bits(64'h0_0000_0001, 37);
      step(1'b1, 1'b0);
      chk("bad_cfg", 64'(CFG), 64'h1_0000_FFFF);
      chk("bad_err", 64'(CFG_ERR), 64'd1);
      chk("bad_done", 64'(done_cnt), 64'd0);
      idle(3);
      chk("bad_err_sticky", 64'(CFG_ERR), 64'd1);

      // Good frame clears the error
      start_frame();
      send_bits(64'b0010, 4);
      send_bits(64'h0_0000_0003, 37);
      step(1'b1, 1'b0);
      chk("clr_cfg", 64'(CFG), 64'h0_0000_0003);
      chk("clr_err", 64'(CFG_ERR), 64'd0);
      chk("clr_done", 64'(CFG_DONE), 64'd1);
      idle(1);

      // Stalled frame: 5 idle cycles at bit 10 and 5 in PARITY
      start_frame();
      send_bits(64'b0010, 4);
      send_bits(64'(37'h1_0000_FFFF >> 27), 10);
      idle(5);
      chk("stall_busy_hold", 64'(BUSY), 64'd1);
      chk("stall_cfg_hold", 64'(CFG), 64'h0_0000_0003);
      send_bits(64'(37'h1_0000_FFFF) & 64'h7FF_FFFF, 27);
      idle(5);
      chk("stall_busy_par", 64'(BUSY), 64'd1);
      chk("stall_no_early_done", 64'(done_cnt), 64'd0);
      step(1'b1, 1'b1);
      chk("stall_cfg", 64'(CFG), 64'h1_0000_FFFF);
      chk("stall_done", 64'(CFG_DONE), 64'd1);
      chk("stall_done_edge", 64'(edges), 64'd52);
      chk("stall_busy_cycles", 64'(busy_cnt), 64'd48);
      idle(1);

      // Reset mid-frame, then trailing bits without a preamble
      start_frame();
      send_bits(64'b0010, 4);
      send_bits(64'(37'h0_A5A5_A5A5 >> 17), 20);
      RSTN = 1'b0;
      step(1'b1, 1'b1);
      RSTN = 1'b1;
      chk("mid_rst_cfg", 64'(CFG), 64'(Init));
      chk("mid_rst_busy", 64'(BUSY), 64'd0);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 18; i++) step(1'b1, 1'b1);
      chk("mid_trail_cfg", 64'(CFG), 64'(Init));
      chk("mid_trail_busy", 64'(busy_cnt), 64'd0);
      chk("mid_trail_done", 64'(done_cnt), 64'd0);

      // Preamble hidden in noise, body containing the preamble pattern
      start_frame();
      send_bits(64'b111001, 6);
      chk("noise_not_locked", 64'(BUSY), 64'd0);
      step(1'b1, 1'b0);
      chk("noise_locked", 64'(BUSY), 64'd1);
      send_bits(64'h0_0123_0010, 37);
      step(1'b1, 1'b1);
      chk("noise_cfg", 64'(CFG), 64'h0_0123_0010);
      chk("noise_done", 64'(CFG_DONE), 64'd1);
      chk("noise_busy_cycles", 64'(busy_cnt), 64'd38);
      chk("noise_err", 64'(CFG_ERR), 64'd0);
      idle(2);
      chk("noise_done_count", 64'(done_cnt), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
